// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   This block produces the opcode and func stream for the single-cycle
//   control unit. It holds the PC and fetches 16-bit instruction words over a
//   req/valid handshake. Each word is latched into the instruction register
//   (ir), and its decode fields are presented for one issue cycle. The issue
//   cycle is extended while the downstream stall input is high. The next PC
//   comes from the control unit's nia input and the datapath branch result.
//
// Sequencing:
//   IDLE -> FETCH -> ISSUE -> FETCH ...
//   With a zero-wait memory, one instruction issues every 2 cycles.
//
// Parameters:
//   ADDR_W    PC / imem word-address width. Must be at least 13, because a
//             jump replaces PC[11:0].
//   RESET_PC  PC value loaded on reset.
//
// Ports:
//   clk           in   1       single clock, rising edge
//   rst           in   1       synchronous, active-high reset
//   imem_req      out  1       fetch request, high for the whole FETCH state
//   imem_addr     out  ADDR_W  word address of the fetch (= PC)
//   imem_rdata    in   16      instruction word, qualified by imem_valid
//   imem_valid    in   1       rdata valid; only honoured in FETCH
//   stall         in   1       downstream hold; freezes ISSUE
//   nia           in   1       1 = sequential/branch path, 0 = jump
//   branch_taken  in   1       branch condition, used only when nia = 1
//   instr_valid   out  1       decode fields valid (ISSUE state)
//   opcode        out  4       ir[15:12]
//   rs, rt, rd    out  3 each  ir[11:9], ir[8:6], ir[5:3]
//   func          out  3       ir[2:0]
//   imm_sext      out  16      sign-extended ir[5:0]
//   jmp_target    out  12      ir[11:0]
//   pc_out        out  ADDR_W  address of the issuing instruction
//   illegal       out  1       one-cycle pulse when an unknown opcode issues
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    input  logic              stall,
    input  logic              nia,
    input  logic              branch_taken,
    output logic              instr_valid,
    output logic [3:0]        opcode,
    output logic [2:0]        rs,
    output logic [2:0]        rt,
    output logic [2:0]        rd,
    output logic [2:0]        func,
    output logic [15:0]       imm_sext,
    output logic [11:0]       jmp_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic              illegal
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    // Legal opcodes are 0, 2, 4, 8, 11 and 15. Bit n of this mask is set
    // when opcode n is legal.
    localparam logic [15:0] LEGAL_MASK = 16'b1000_1001_0001_0101;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    // first_q is set for the first cycle of each ISSUE. It keeps illegal to a
    // single pulse while the instruction is held by stall.
    logic              first_q, first_d;

    logic              opcode_legal;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] jump_pc;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] next_pc;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            first_q <= first_d;
        end
    end

    // ------------------------------------------------------ next-PC compute
    assign opcode_legal = LEGAL_MASK[ir_q[15:12]];
    assign seq_pc       = pc_q + ADDR_W'(1);
    // A jump keeps the current 4K-word page and replaces the low 12 bits.
    assign jump_pc      = {pc_q[ADDR_W-1:12], ir_q[11:0]};
    assign branch_off   = {{(ADDR_W-6){ir_q[5]}}, ir_q[5:0]};
    assign branch_pc    = seq_pc + branch_off;

    // An unknown opcode always falls through to PC + 1, whatever the
    // control unit says. Otherwise a jump takes priority over branch_taken.
    always_comb begin
        next_pc = seq_pc;
        if (opcode_legal) begin
            if (!nia) begin
                next_pc = jump_pc;
            end else if (branch_taken) begin
                next_pc = branch_pc;
            end
        end
    end

    // ------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        first_d = first_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    first_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                first_d = 1'b0;
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_ISSUE);
    assign illegal     = (state_q == ST_ISSUE) && first_q && !opcode_legal;
    assign pc_out      = pc_q;

    // The field outputs are driven straight from ir, so they read 0 after reset.
    assign opcode      = ir_q[15:12];
    assign rs          = ir_q[11:9];
    assign rt          = ir_q[8:6];
    assign rd          = ir_q[5:3];
    assign func        = ir_q[2:0];
    assign imm_sext    = {{10{ir_q[5]}}, ir_q[5:0]};
    assign jmp_target  = ir_q[11:0];

endmodule
